// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locked arbiter sharing one UART TX core between NUM_REQ byte streams.
// Define ARB_TIMEOUT_EN to force release of an owner that stalls mid-frame for TIMEOUT_CYC cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic                      timeout_pulse
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               slot_free;
    logic               accept;
    logic               tmo_hit;
    logic [DATA_W-1:0]  owner_data;

    // Scan downward so the candidate closest to rr_ptr is the one left standing.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_idx = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(idx);
            end
        end
    end

    assign owner_data = req_data[int'(owner)*DATA_W +: DATA_W];
    assign slot_free  = !tx_valid || tx_ready;
    assign accept     = (state == XFER) && req_valid[owner] && slot_free;
    assign busy       = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (state == XFER)
            req_ready[owner] = slot_free;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] idle_cnt;

    assign tmo_hit = (state == XFER) && !req_valid[owner] &&
                     (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            idle_cnt <= '0;
        else if (state != XFER || accept || tmo_hit)
            idle_cnt <= '0;
        else if (!req_valid[owner])
            idle_cnt <= idle_cnt + CNT_W'(1);
    end
`else
    // Timeout length has no effect when forced release is compiled out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYC;
    assign tmo_hit            = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            grant         <= '0;
            owner         <= '0;
            rr_ptr        <= '0;
            tx_valid      <= 1'b0;
            tx_data       <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;

            if (accept) begin
                tx_data  <= owner_data;
                tx_valid <= 1'b1;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state  <= XFER;
                        owner  <= pick_idx;
                        grant  <= NUM_REQ'(1) << pick_idx;
                        rr_ptr <= (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
                    end
                end
                XFER: begin
                    if (accept && req_last[owner]) begin
                        state <= DRAIN;
                    end else if (tmo_hit) begin
                        state         <= DRAIN;
                        timeout_pulse <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (slot_free) begin
                        state <= IDLE;
                        grant <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues feed the DUT,
// expected {grant, byte} pairs are queued by the tests and popped by a TX monitor.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [NUM_REQ-1:0] gnt;
        logic [DATA_W-1:0]  data;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready;
    logic                      timeout_pulse;

    beat_t rq[NUM_REQ][$];
    exp_t  sb[$];
    int    fire_cyc[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit saw_pulse   = 0;

    logic              prev_fire;
    logic [DATA_W-1:0] prev_byte;
    logic              prev_tv;
    logic              prev_tr;
    logic [DATA_W-1:0] prev_td;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(1024)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .grant         (grant),
        .busy          (busy),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        tx_ready = v;
    endtask

    task automatic push_beat(input int i, input logic l, input logic [DATA_W-1:0] d);
        beat_t b;
        b.last = l;
        b.data = d;
        rq[i].push_back(b);
    endtask

    task automatic expect_tx(input logic [NUM_REQ-1:0] g, input logic [DATA_W-1:0] d);
        exp_t e;
        e.gnt  = g;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_sb(input string name, input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic wait_txv(input string name, input int limit);
        int n = 0;
        while (!tx_valid && n < limit) begin
            tick();
            n++;
        end
        check(name, {31'd0, tx_valid}, 1);
    endtask

    // Requester model: each queue front is presented until the DUT takes it.
    initial begin
        logic [NUM_REQ-1:0] fire;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fire[i] && rq[i].size() > 0)
                    void'(rq[i].pop_front());
                req_valid[i] = (rq[i].size() > 0);
                if (rq[i].size() > 0) begin
                    req_data[i*DATA_W +: DATA_W] = rq[i][0].data;
                    req_last[i]                  = rq[i][0].last;
                end
            end
        end
    end

    // TX monitor: scoreboard pop, accept-to-output latency, hold under backpressure.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (timeout_pulse)
            saw_pulse = 1'b1;
        if (reset_n) begin
            if (tx_valid && tx_ready) begin
                fire_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_unexpected: got grant=%b data=0x%0h, expected no byte", grant, tx_data);
                end else begin
                    e = sb.pop_front();
                    check("tx_byte", {20'd0, grant, tx_data}, {20'd0, e.gnt, e.data});
                end
            end
            if (prev_fire)
                check("tx_latency", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_byte});
            if (prev_tv && !prev_tr)
                check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_td});
        end
        prev_fire = 1'b0;
        prev_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset_n && req_valid[i] && req_ready[i]) begin
                prev_fire = 1'b1;
                prev_byte = req_data[i*DATA_W +: DATA_W];
            end
        end
        prev_tv = reset_n && tx_valid;
        prev_tr = tx_ready;
        prev_td = tx_data;
    end

    initial begin
        tx_ready = 1'b0;
        reset_n  = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) tick();
        check("rst_grant", {28'd0, grant}, 0);
        check("rst_tx_valid", {31'd0, tx_valid}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_req_ready", {28'd0, req_ready}, 0);
        check("rst_timeout", {31'd0, timeout_pulse}, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // Reset while a byte sits stalled in the output register.
        tick();
        push_beat(0, 1'b0, 8'h11);
        push_beat(0, 1'b0, 8'h12);
        push_beat(0, 1'b1, 8'h13);
        wait_txv("t1_tx_valid_up", 20);
        rq[0].delete();
        #1 reset_n = 1'b0;
        #1;
        check("t1_async_tx_valid", {31'd0, tx_valid}, 0);
        check("t1_async_grant", {28'd0, grant}, 0);
        check("t1_async_busy", {31'd0, busy}, 0);
        check("t1_async_tx_data", {24'd0, tx_data}, 0);
        repeat (2) tick();
        @(posedge clk);
        #3 reset_n = 1'b1;

        // All four requesters, one-byte frames, rotation from index 0.
        set_ready(1'b1);
        tick();
        push_beat(0, 1'b1, 8'hB0);
        push_beat(0, 1'b1, 8'hB4);
        push_beat(1, 1'b1, 8'hB1);
        push_beat(2, 1'b1, 8'hB2);
        push_beat(3, 1'b1, 8'hB3);
        expect_tx(4'b0001, 8'hB0);
        expect_tx(4'b0010, 8'hB1);
        expect_tx(4'b0100, 8'hB2);
        expect_tx(4'b1000, 8'hB3);
        expect_tx(4'b0001, 8'hB4);
        wait_sb("t3_rotation_done", 60);

        // Three-byte frame from requester 0 streams at one byte per cycle.
        repeat (4) tick();
        fire_cyc.delete();
        push_beat(0, 1'b0, 8'hA1);
        push_beat(0, 1'b0, 8'hA2);
        push_beat(0, 1'b1, 8'hA3);
        expect_tx(4'b0001, 8'hA1);
        expect_tx(4'b0001, 8'hA2);
        expect_tx(4'b0001, 8'hA3);
        wait_sb("t2_frame_done", 30);
        check("t2_byte_count", fire_cyc.size(), 3);
        if (fire_cyc.size() == 3) begin
            check("t2_gap_1", fire_cyc[1] - fire_cyc[0], 1);
            check("t2_gap_2", fire_cyc[2] - fire_cyc[1], 1);
        end
        repeat (3) tick();
        check("t2_busy_after", {31'd0, busy}, 0);
        check("t2_grant_after", {28'd0, grant}, 0);

        // Backpressure: TX core stalls with the first byte of requester 1 pending.
        set_ready(1'b0);
        tick();
        push_beat(1, 1'b0, 8'hC1);
        push_beat(1, 1'b0, 8'hC2);
        push_beat(1, 1'b1, 8'hC3);
        expect_tx(4'b0010, 8'hC1);
        expect_tx(4'b0010, 8'hC2);
        expect_tx(4'b0010, 8'hC3);
        wait_txv("t4_tx_valid_up", 20);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_req_ready_low", {28'd0, req_ready}, 0);
            check("t4_tx_data_held", {24'd0, tx_data}, 32'hC1);
        end
        set_ready(1'b1);
        tick();
        wait_sb("t4_frame_done", 30);

        // Owner 2 mid-frame while requesters 1 and 3 wait; 3 is next in rotation.
        tick();
        push_beat(2, 1'b0, 8'hD1);
        expect_tx(4'b0100, 8'hD1);
        wait_sb("t5_first_byte", 20);
        push_beat(1, 1'b1, 8'hE1);
        push_beat(3, 1'b1, 8'hF1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_req_ready_1", {31'd0, req_ready[1]}, 0);
            check("t5_req_ready_3", {31'd0, req_ready[3]}, 0);
            check("t5_grant_held", {28'd0, grant}, 32'b0100);
        end
        push_beat(2, 1'b1, 8'hD2);
        expect_tx(4'b0100, 8'hD2);
        expect_tx(4'b1000, 8'hF1);
        expect_tx(4'b0010, 8'hE1);
        wait_sb("t5_handover_done", 40);

        // With 3 absent after owner 2, the rotation wraps to 1.
        tick();
        push_beat(2, 1'b1, 8'h5A);
        push_beat(1, 1'b1, 8'hA5);
        expect_tx(4'b0100, 8'h5A);
        expect_tx(4'b0010, 8'hA5);
        wait_sb("t5_wrap_done", 30);

        // Owner stalls mid-frame: no forced release in the default build.
        tick();
        saw_pulse = 1'b0;
        push_beat(0, 1'b0, 8'h71);
        expect_tx(4'b0001, 8'h71);
        wait_sb("t6_first_byte", 20);
        repeat (1100) tick();
        check("t6_grant_held", {28'd0, grant}, 32'b0001);
        check("t6_busy_held", {31'd0, busy}, 1);
        check("t6_no_timeout", {31'd0, saw_pulse}, 0);
        push_beat(0, 1'b1, 8'h72);
        expect_tx(4'b0001, 8'h72);
        wait_sb("t6_frame_done", 20);

        repeat (4) tick();
        check("end_busy", {31'd0, busy}, 0);
        check("end_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
